sponge_absorb_ctrl: RTL and testbench
=====================================

# sponge_absorb_ctrl

Byte-stream absorb controller for the KMAC/SHA-3 sponge. It collects message bytes into rate-sized blocks and applies pad10*1 with a domain-separation suffix to the final block. It hands each block to the Keccak-f permutation wrapper over a valid/ready handshake. It sits between the message source (KMAC framing logic) and the permutation core, and sequences every absorb including the extra padding block.

## Interface
- RATE_BYTES, 168, sponge rate in bytes (168 = KMAC128/SHAKE128, 136 = SHA3-256/KMAC256); legal range 2..200
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a new message; honoured only in IDLE
- empty_i  in  1  sampled with start: message has zero bytes
- ds_i  in  8  domain-separation byte incl. first pad bit (0x06 SHA3, 0x1F SHAKE, 0x04 cSHAKE/KMAC), sampled with start
- in_valid  in  1  message byte valid
- in_data  in  8  message byte
- in_last  in  1  qualifies in_data as final byte
- in_ready  out  1  controller accepts a byte this cycle
- blk_valid  out  1  block available to permutation
- blk_data  out  RATE_BYTES*8  block; byte i at bits [8i+7:8i]
- blk_last  out  1  block is the final (padded) block
- blk_ready  in  1  permutation accepts block
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse after final block handshake
- blk_cnt  out  16  blocks emitted for current message, saturating at 0xFFFF

## Operation
- States: IDLE, ABSORB, PAD, EMIT, DONE.
- Internals: buffer (RATE_BYTES bytes), idx (byte index), ds register, pad_pending flag, final flag.
- IDLE: in_ready=0.
  - start: latch ds_i, zero buffer, idx=0, blk_cnt=0, final=0.
  - start with empty_i=1 → PAD; start with empty_i=0 → ABSORB.
- ABSORB: in_ready=1. On in_valid && in_ready, buffer[idx] ← in_data.
  - Not last, idx<RATE_BYTES-1: idx++, stay in ABSORB.
  - Not last, idx==RATE_BYTES-1: → EMIT, pad_pending=0.
  - Last, idx<RATE_BYTES-1: idx++, → PAD.
  - Last, idx==RATE_BYTES-1: → EMIT, pad_pending=1. Block is full, so a separate all-padding block follows.
- PAD, one cycle:
  - buffer[idx] ^= ds.
  - buffer[RATE_BYTES-1] ^= 0x80.
  - When idx==RATE_BYTES-1, that byte becomes ds^0x80.
  - Set final=1, → EMIT.
- EMIT: blk_valid=1, in_ready=0, blk_last=final. On blk_ready:
  - Increment blk_cnt.
  - Zero buffer, idx=0.
  - Next state: final → DONE; pad_pending → PAD (clear pad_pending); otherwise → ABSORB.
- DONE: done=1 for one cycle, → IDLE.
- Bytes of the buffer not written are always 0, because the buffer is zeroed at start and after every emit.
- start outside IDLE is ignored. in_valid outside ABSORB is ignored (in_ready=0).

## Timing
- Reset values: state IDLE, in_ready=0, blk_valid=0, blk_last=0, blk_data=0, busy=0, done=0, blk_cnt=0.
- Reset mid-operation discards the partial block. The next start behaves as from power-up.
- Throughput: one byte per cycle in ABSORB.
- Full block: blk_valid asserts the cycle after the RATE_BYTES-th byte is accepted.
- Last byte accepted at cycle t (partial block): PAD at t+1, blk_valid at t+2.
- Empty message: start at t, PAD at t+1, blk_valid at t+2.
- Handshake completes on the cycle where blk_valid && blk_ready.
  - blk_data and blk_last are held stable while blk_valid && !blk_ready.
  - blk_valid does not drop without a handshake.
- done pulses the cycle after the final handshake. busy drops the cycle after that.
- blk_data is driven directly from the buffer register, with no combinational path from in_data.

## Test plan
Bench uses RATE_BYTES=8. Bytes are listed byte0..byte7.
- Empty message, ds=0x06: start+empty_i → one block 06 00 00 00 00 00 00 80, blk_last=1, blk_valid at start+2, done one cycle after handshake, blk_cnt=1.
- Bytes AA BB CC (CC with in_last), ds=0x04 → AA BB CC 04 00 00 00 80, blk_last=1.
- Bytes 01..07 (07 last), ds=0x1F → 01 02 03 04 05 06 07 9F; single block.
- Bytes 01..08 (08 last), ds=0x06 → block 01..08 with blk_last=0, then 06 00 00 00 00 00 00 80 with blk_last=1; blk_cnt=2.
- 17 bytes with blk_ready held low 5 cycles on each block:
  - blk_data stable throughout, in_ready=0 during EMIT.
  - Three blocks emitted, third = 11 06 00 00 00 00 00 80 (for bytes 01..11 hex, ds=0x06).
  - No byte lost or duplicated.
- rst_n asserted mid-ABSORB after 3 bytes → all outputs at reset values immediately; a new empty-message start then yields 06 00 … 80 with blk_cnt=1.

Source files
------------

// File: rtl/sponge_absorb_ctrl.sv
// sponge_absorb_ctrl: packs message bytes into rate blocks, applies pad10*1 with domain suffix, hands blocks to Keccak-f
module sponge_absorb_ctrl #(
  parameter int RATE_BYTES = 168
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    empty_i,
  input  logic [7:0]              ds_i,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    blk_valid,
  output logic [RATE_BYTES*8-1:0] blk_data,
  output logic                    blk_last,
  input  logic                    blk_ready,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             blk_cnt
);
  localparam int W = RATE_BYTES * 8;
  localparam int IW = $clog2(RATE_BYTES);
  localparam logic [IW-1:0] LAST = IW'(RATE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, ABSORB, PAD, EMIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   buf_q, pad_vec;
  logic [IW-1:0]  idx_q;
  logic [7:0]     ds_q;
  logic           pad_pending_q, final_q;

  // ds lands on the next free byte and 0x80 on the top byte; they merge when idx is the top byte
  always_comb pad_vec = (W'(ds_q) << {idx_q, 3'b000}) ^ {8'h80, {(W-8){1'b0}}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (empty_i ? PAD : ABSORB) : IDLE;
      ABSORB:  state_d = !in_valid ? ABSORB : (idx_q == LAST) ? EMIT : in_last ? PAD : ABSORB;
      PAD:     state_d = EMIT;
      EMIT:    state_d = !blk_ready ? EMIT : final_q ? DONE : pad_pending_q ? PAD : ABSORB;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      idx_q         <= '0;
      ds_q          <= '0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      blk_cnt       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          ds_q          <= ds_i;
          buf_q         <= '0;
          idx_q         <= '0;
          blk_cnt       <= '0;
          final_q       <= 1'b0;
          pad_pending_q <= 1'b0;
        end
        ABSORB: if (in_valid) begin
          buf_q[{idx_q, 3'b000} +: 8] <= in_data;
          if (idx_q == LAST) pad_pending_q <= in_last;
          else idx_q <= idx_q + 1'b1;
        end
        PAD: begin
          buf_q   <= buf_q ^ pad_vec;
          final_q <= 1'b1;
        end
        EMIT: if (blk_ready) begin
          blk_cnt       <= blk_cnt + {15'd0, blk_cnt != 16'hFFFF};
          buf_q         <= '0;
          idx_q         <= '0;
          pad_pending_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = state_q == ABSORB;
  assign blk_valid = state_q == EMIT;
  assign blk_last  = blk_valid && final_q;
  assign blk_data  = buf_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_sponge_absorb_ctrl.sv
// tb_sponge_absorb_ctrl: scoreboard bench for sponge_absorb_ctrl at RATE_BYTES=8
module tb_sponge_absorb_ctrl;
  logic        clk = 0, rst_n = 0, start = 0, empty_i = 0, in_valid = 0, in_last = 0, blk_ready = 0;
  logic [7:0]  ds_i = 0, in_data = 0;
  logic        in_ready, blk_valid, blk_last, busy, done;
  logic [63:0] blk_data;
  logic [15:0] blk_cnt;

  int n_chk = 0, n_fail = 0, stall = 0;

  typedef struct {logic [63:0] data; logic last;} blk_t;
  blk_t exp_q[$];

  sponge_absorb_ctrl #(.RATE_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .empty_i(empty_i), .ds_i(ds_i),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last), .blk_ready(blk_ready),
    .busy(busy), .done(done), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    blk_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Permutation side: holds blk_ready low for `stall` cycles of each block
  initial begin
    int w = 0;
    forever begin
      @(posedge clk); #1;
      if (blk_valid && !blk_ready) begin
        if (w >= stall) blk_ready = 1;
        else w++;
      end else begin
        blk_ready = 0;
        w = 0;
      end
    end
  end

  // Monitor: pops on every handshake, and checks hold-stability while stalled
  initial begin
    logic        held = 0;
    logic [63:0] hd;
    logic        hl;
    blk_t        e;
    forever begin
      @(negedge clk);
      if (blk_valid && rst_n) begin
        chk("in_ready_in_emit", {63'd0, in_ready}, 64'd0);
        if (held) begin
          chk("blk_data_stable", blk_data, hd);
          chk("blk_last_stable", {63'd0, blk_last}, {63'd0, hl});
        end
        if (blk_ready) begin
          if (exp_q.size() == 0) chk("unexpected_block", blk_data, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("blk_data", blk_data, e.data);
            chk("blk_last", {63'd0, blk_last}, {63'd0, e.last});
          end
        end
        held = !blk_ready;
        hd = blk_data;
        hl = blk_last;
      end else held = 0;
    end
  end

  task automatic do_start(input logic emp, input logic [7:0] ds);
    start = 1; empty_i = emp; ds_i = ds;
    @(posedge clk); #1;
    start = 0; empty_i = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    logic acc;
    in_valid = 1; in_data = d; in_last = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_done(input string nm, input logic [15:0] cnt);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 500);
    chk({nm, "_done"}, {63'd0, done}, 64'd1);
    chk({nm, "_blk_cnt"}, {48'd0, blk_cnt}, {48'd0, cnt});
    @(negedge clk);
    chk({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({nm, "_busy_drop"}, {63'd0, busy}, 64'd0);
    chk({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({nm, "_blk_valid"}, {63'd0, blk_valid}, 64'd0);
    chk({nm, "_blk_last"}, {63'd0, blk_last}, 64'd0);
    chk({nm, "_blk_data"}, blk_data, 64'd0);
    chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
    chk({nm, "_done"}, {63'd0, done}, 64'd0);
    chk({nm, "_blk_cnt"}, {48'd0, blk_cnt}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Empty message: PAD one cycle after start, blk_valid two cycles after
    push(64'h8000000000000006, 1);
    do_start(1, 8'h06);
    @(negedge clk);
    chk("empty_valid_t1", {63'd0, blk_valid}, 64'd0);
    @(negedge clk);
    chk("empty_valid_t2", {63'd0, blk_valid}, 64'd1);
    wait_done("empty", 16'd1);

    push(64'h8000000004CCBBAA, 1);
    do_start(0, 8'h04);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    wait_done("abc", 16'd1);

    push(64'h9F07060504030201, 1);
    do_start(0, 8'h1F);
    for (int i = 1; i <= 7; i++) send(8'(i), i == 7);
    wait_done("seven", 16'd1);

    push(64'h0807060504030201, 0);
    push(64'h8000000000000006, 1);
    do_start(0, 8'h06);
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    wait_done("full", 16'd2);

    stall = 5;
    push(64'h0807060504030201, 0);
    push(64'h100F0E0D0C0B0A09, 0);
    push(64'h8000000000000611, 1);
    do_start(0, 8'h06);
    for (int i = 1; i <= 17; i++) send(8'(i), i == 17);
    wait_done("stall17", 16'd3);
    stall = 0;

    // Asynchronous reset mid-absorb drops the partial block
    do_start(0, 8'h06);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    rst_n = 0;
    #1 chk_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    push(64'h8000000000000006, 1);
    do_start(1, 8'h06);
    wait_done("post_rst", 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
